// File: rtl/pc_pkg.sv
// Shared definitions for the PC generator: next-PC source encoding,
// run/halt state type and default vectors.
package pc_pkg;

  localparam logic [2:0] SRC_SEQ    = 3'b000;
  localparam logic [2:0] SRC_BRANCH = 3'b001;
  localparam logic [2:0] SRC_JUMP   = 3'b010;
  localparam logic [2:0] SRC_REG    = 3'b011;
  localparam logic [2:0] SRC_RET    = 3'b100;
  localparam logic [2:0] SRC_TRAP   = 3'b101;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } pc_state_e;

  localparam logic [31:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [31:0] DEF_TRAP_VEC  = 32'h0000_0100;

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. A push into a full stack overwrites the
// oldest entry; push and pop together replace the top entry in place.
module pc_ras #(
  parameter int XLEN      = 32,
  parameter int RAS_DEPTH = 4
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   CNT_ONE = (PW + 1)'(1);
  localparam logic [PW:0]   CNT_MAX = (PW + 1)'(RAS_DEPTH);

  logic [XLEN-1:0] mem [RAS_DEPTH];
  logic [PW-1:0]   ptr;    // next free slot; wraps over the oldest entry
  logic [PW:0]     count;  // occupancy, saturates at RAS_DEPTH
  logic [PW-1:0]   tos;
  logic            do_pop;

  assign tos    = ptr - PTR_ONE;
  assign top    = mem[tos];
  assign empty  = (count == '0);
  assign full   = (count == CNT_MAX);
  assign do_pop = pop && !empty;

  // Pointer and occupancy bookkeeping; a combined push+pop leaves both alone.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (push && do_pop) begin
      ptr   <= ptr;
    end else if (push) begin
      ptr <= ptr + PTR_ONE;
      if (!full) count <= count + CNT_ONE;
    end else if (do_pop) begin
      ptr   <= ptr - PTR_ONE;
      count <= count - CNT_ONE;
    end
  end

  // Entry storage, deliberately not reset; combined push+pop rewrites the top.
  always_ff @(posedge CLK) begin
    if (push) mem[do_pop ? tos : ptr] <= push_data;
  end

endmodule

// File: rtl/pc_gen.sv
// Program counter generator: next-PC selection, run/halt control, trap and
// misalignment handling with sticky fault, and a return-address stack.
module pc_gen
  import pc_pkg::*;
#(
  parameter int              XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEF_RESET_VEC),
  parameter logic [XLEN-1:0] TRAP_VEC  = XLEN'(DEF_TRAP_VEC),
  parameter int              RAS_DEPTH = 4
) (
  input  logic            CLK,
  input  logic            Reset,
  input  logic            PCWre,
  input  logic [2:0]      PCSrc,
  input  logic            BrTaken,
  input  logic [XLEN-1:0] Imm,
  input  logic [25:0]     JTarget,
  input  logic [XLEN-1:0] RegTarget,
  input  logic            Call,
  input  logic            Halt,
  input  logic            Resume,
  output logic [XLEN-1:0] curPC,
  output logic [XLEN-1:0] nextPC,
  output logic [XLEN-1:0] epc,
  output logic            halted,
  output logic            ras_empty,
  output logic            ras_full,
  output logic            fault
);

  pc_state_e       state, state_nxt;
  logic [XLEN-1:0] pc4, ras_top;
  logic            upd, is_ret, ret_empty, misalign, flt, ras_push, ras_pop;

  assign pc4 = curPC + XLEN'(4);

  // Combinational next-address candidate; reserved encodings fall back to SEQ.
  always_comb begin
    nextPC = pc4;
    case (PCSrc)
      SRC_BRANCH: if (BrTaken) nextPC = pc4 + {Imm[XLEN-3:0], 2'b00};
      SRC_JUMP:   nextPC = {pc4[XLEN-1:28], JTarget, 2'b00};
      SRC_REG:    nextPC = RegTarget;
      SRC_RET:    nextPC = ras_top;
      SRC_TRAP:   nextPC = TRAP_VEC;
      default:    nextPC = pc4;
    endcase
  end

  // A faulting update redirects to TRAP_VEC and leaves the stack untouched.
  assign upd       = (state == ST_RUN) && PCWre && !Halt;
  assign is_ret    = (PCSrc == SRC_RET);
  assign ret_empty = is_ret && ras_empty;
  assign misalign  = |nextPC[1:0];
  assign flt       = ret_empty || misalign;
  assign ras_push  = upd && Call && !flt;
  assign ras_pop   = upd && is_ret && !flt;
  assign halted    = (state == ST_HALT);

  // Run/halt state register.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) state <= ST_RUN;
    else        state <= state_nxt;
  end

  // Halt wins over PCWre in RUN; only Resume matters in HALT.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_RUN:  if (Halt)   state_nxt = ST_HALT;
      ST_HALT: if (Resume) state_nxt = ST_RUN;
      default: state_nxt = ST_RUN;
    endcase
  end

  // PC, exception PC and sticky fault update.
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      curPC <= RESET_VEC;
      epc   <= '0;
      fault <= 1'b0;
    end else if (upd) begin
      if (flt) begin
        curPC <= TRAP_VEC;
        epc   <= curPC;
        fault <= 1'b1;
      end else begin
        curPC <= nextPC;
        if (PCSrc == SRC_TRAP) epc <= curPC;
      end
    end
  end

  pc_ras #(.XLEN(XLEN), .RAS_DEPTH(RAS_DEPTH)) u_ras (
    .CLK       (CLK),
    .Reset     (Reset),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc4),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );

endmodule

// File: tb/tb_pc_gen.sv
// Bench for pc_gen: directed scenarios then random traffic, each cycle
// checked against a queue-based behavioural model.
module tb_pc_gen;

  localparam logic [31:0] TRAP = 32'h0000_0100;
  localparam int DEPTH = 4;

  logic        CLK = 1'b0;
  logic        Reset;
  logic        PCWre, BrTaken, Call, Halt, Resume;
  logic [2:0]  PCSrc;
  logic [31:0] Imm, RegTarget;
  logic [25:0] JTarget;
  logic [31:0] curPC, nextPC, epc;
  logic        halted, ras_empty, ras_full, fault;

  int checks = 0;
  int failures = 0;

  // model state
  logic [31:0] m_pc, m_epc;
  logic        m_fault, m_halted;
  logic [31:0] m_ras[$];

  pc_gen dut (
    .CLK(CLK), .Reset(Reset), .PCWre(PCWre), .PCSrc(PCSrc), .BrTaken(BrTaken),
    .Imm(Imm), .JTarget(JTarget), .RegTarget(RegTarget), .Call(Call),
    .Halt(Halt), .Resume(Resume), .curPC(curPC), .nextPC(nextPC), .epc(epc),
    .halted(halted), .ras_empty(ras_empty), .ras_full(ras_full), .fault(fault)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = 32'h0; m_epc = 32'h0; m_fault = 1'b0; m_halted = 1'b0;
    m_ras.delete();
  endtask

  task automatic check_state(input string tag);
    check({tag, ".curPC"}, curPC, m_pc);
    check({tag, ".epc"}, epc, m_epc);
    check({tag, ".fault"}, {31'b0, fault}, {31'b0, m_fault});
    check({tag, ".halted"}, {31'b0, halted}, {31'b0, m_halted});
    check({tag, ".ras_empty"}, {31'b0, ras_empty}, {31'b0, m_ras.size() == 0});
    check({tag, ".ras_full"}, {31'b0, ras_full}, {31'b0, m_ras.size() == DEPTH});
  endtask

  // Called at posedge+1: drive, check candidate, clock, advance model, check.
  task automatic step(input string tag, input logic [2:0] src, input logic we,
                      input logic br, input logic [31:0] imm, input logic [25:0] jt,
                      input logic [31:0] rt, input logic call, input logic hlt,
                      input logic res);
    logic [31:0] pc4, cand;
    logic upd, flt, ret_empty;
    PCSrc = src; PCWre = we; BrTaken = br; Imm = imm; JTarget = jt;
    RegTarget = rt; Call = call; Halt = hlt; Resume = res;
    pc4 = m_pc + 32'd4;
    ret_empty = (src == 3'd4) && (m_ras.size() == 0);
    case (src)
      3'd1:    cand = br ? pc4 + imm * 4 : pc4;
      3'd2:    cand = (pc4 & 32'hF000_0000) | ({6'b0, jt} * 4);
      3'd3:    cand = rt;
      3'd4:    cand = ret_empty ? 32'h0 : m_ras[m_ras.size() - 1];
      3'd5:    cand = TRAP;
      default: cand = pc4;
    endcase
    #1;
    if (!ret_empty) check({tag, ".nextPC"}, nextPC, cand);
    upd = !m_halted && we && !hlt;
    @(posedge CLK); #1;
    if (m_halted) begin
      if (res) m_halted = 1'b0;
    end else if (hlt) begin
      m_halted = 1'b1;
    end
    if (upd) begin
      flt = ret_empty || (cand % 4 != 0);
      if (flt) begin
        m_epc = m_pc; m_pc = TRAP; m_fault = 1'b1;
      end else begin
        if (src == 3'd5) m_epc = m_pc;
        m_pc = cand;
        if (src == 3'd4) void'(m_ras.pop_back());
        if (call) begin
          m_ras.push_back(pc4);
          if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end
      end
    end
    check_state(tag);
  endtask

  initial begin
    logic [31:0] rets[4];
    logic [31:0] frozen, rt, imm;
    Reset = 1'b0; PCWre = 0; PCSrc = 0; BrTaken = 0; Imm = 0; JTarget = 0;
    RegTarget = 0; Call = 0; Halt = 0; Resume = 0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    check_state("reset");
    Reset = 1'b1;

    // sequential fetch 0,4,8,C
    step("seq1", 3'd0, 1, 0, 0, 0, 0, 0, 0, 0); check("seq1.k", curPC, 32'h4);
    step("seq2", 3'd0, 1, 0, 0, 0, 0, 0, 0, 0); check("seq2.k", curPC, 32'h8);
    step("seq3", 3'd0, 1, 0, 0, 0, 0, 0, 0, 0); check("seq3.k", curPC, 32'hC);
    step("seq4", 3'd0, 1, 0, 0, 0, 0, 0, 0, 0);
    // backward branch and jump
    step("br", 3'd1, 1, 1, -32'sd2, 0, 0, 0, 0, 0); check("br.k", curPC, 32'hC);
    step("jmp", 3'd2, 1, 0, 0, 26'h40, 0, 0, 0, 0); check("jmp.k", curPC, 32'h100);
    // call / return
    step("reg20", 3'd3, 1, 0, 0, 0, 32'h20, 0, 0, 0);
    step("call", 3'd2, 1, 0, 0, 26'h80, 0, 1, 0, 0);
    step("ret", 3'd4, 1, 0, 0, 0, 0, 0, 0, 0); check("ret.k", curPC, 32'h24);
    for (int i = 0; i < 5; i++) step("push", 3'd0, 1, 0, 0, 0, 0, 1, 0, 0);
    rets = '{32'h38, 32'h34, 32'h30, 32'h2C};
    for (int i = 0; i < 4; i++) begin
      step("pop", 3'd4, 1, 0, 0, 0, 0, 0, 0, 0);
      check("pop.k", curPC, rets[i]);
    end
    check("pop.empty", {31'b0, ras_empty}, 32'h1);
    // misaligned register target, then return with empty stack
    step("reg40", 3'd3, 1, 0, 0, 0, 32'h40, 0, 0, 0);
    step("mis", 3'd3, 1, 0, 0, 0, 32'h102, 0, 0, 0);
    check("mis.pc", curPC, TRAP); check("mis.epc", epc, 32'h40);
    check("mis.fault", {31'b0, fault}, 32'h1);
    step("reg80", 3'd3, 1, 0, 0, 0, 32'h80, 0, 0, 0);
    step("retemp", 3'd4, 1, 0, 0, 0, 0, 1, 0, 0);
    check("retemp.pc", curPC, TRAP); check("retemp.epc", epc, 32'h80);
    // trap source
    step("seq5", 3'd0, 1, 0, 0, 0, 0, 0, 0, 0);
    step("trap", 3'd5, 1, 0, 0, 0, 0, 0, 0, 0); check("trap.epc", epc, 32'h104);
    // halt 3 cycles, resume
    frozen = curPC;
    for (int i = 0; i < 3; i++) begin
      step("halt", 3'd0, 1, 0, 0, 0, 0, 1, 1, 0);
      check("halt.k", curPC, frozen);
    end
    step("resume", 3'd0, 1, 0, 0, 0, 0, 0, 1, 1);
    check("resume.k", {31'b0, halted}, 32'h0);
    step("after", 3'd0, 1, 0, 0, 0, 0, 0, 0, 0); check("after.k", curPC, frozen + 4);
    step("stall", 3'd2, 0, 0, 0, 26'h3, 0, 1, 0, 0);
    step("call2", 3'd0, 1, 0, 0, 0, 0, 1, 0, 0);
    // asynchronous reset in the middle of an update cycle
    PCSrc = 3'd0; PCWre = 1; Call = 1; Halt = 0; Resume = 0;
    #3 Reset = 1'b0;
    #1;
    check("areset.pc", curPC, 32'h0);
    check("areset.fault", {31'b0, fault}, 32'h0);
    check("areset.empty", {31'b0, ras_empty}, 32'h1);
    model_reset();
    PCWre = 0; Call = 0;
    @(negedge CLK); Reset = 1'b1;
    @(posedge CLK); #1;
    check_state("arel");

    // random traffic
    for (int n = 0; n < 400; n++) begin
      logic [2:0] src;
      int r;
      r = $urandom_range(0, 15);
      src = (r < 4) ? 3'd0 : (r < 6) ? 3'd1 : (r < 8) ? 3'd2 : (r < 10) ? 3'd3 :
            (r < 13) ? 3'd4 : (r < 14) ? 3'd5 : 3'($urandom_range(6, 7));
      rt = $urandom & 32'hFFFF_FFFC;
      if ($urandom_range(0, 4) == 0) rt = rt | 32'($urandom_range(1, 3));
      imm = 32'($urandom_range(0, 63)) - 32'd32;
      step("rnd", src, $urandom_range(0, 7) != 0, 1'($urandom), imm, 26'($urandom),
           rt, $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0,
           $urandom_range(0, 2) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
PC_GEN -- requirements
Module: pc_gen

Interface
REQ-001 Parameter XLEN, default 32, address width in bits; legal values are 32 or greater.
REQ-002 Parameter RESET_VEC, default 32'h0000_0000, value loaded into curPC on reset.
REQ-003 Parameter TRAP_VEC, default 32'h0000_0100, redirect target for traps and faults.
REQ-004 Parameter RAS_DEPTH, default 4, number of return-address-stack entries; must be a power of two, 2 or greater.
REQ-005 CLK  in  1  clock; all state changes on the rising edge.
REQ-006 Reset  in  1  asynchronous, active-low reset.
REQ-007 PCWre  in  1  1 = PC may update this cycle; 0 = stall (hold).
REQ-008 PCSrc  in  3  next-PC source: 000 SEQ, 001 BRANCH, 010 JUMP, 011 REG, 100 RET, 101 TRAP; 11x is reserved and treated as SEQ.
REQ-009 BrTaken  in  1  branch condition; used only when PCSrc = BRANCH.
REQ-010 Imm  in  XLEN  sign-extended branch offset, in words.
REQ-011 JTarget  in  26  jump instruction index.
REQ-012 RegTarget  in  XLEN  register-indirect target.
REQ-013 Call  in  1  push PC+4 onto the RAS when the PC updates.
REQ-014 Halt / Resume  in  1 each  enter / leave the HALT state.
REQ-015 curPC  out  XLEN  current instruction address (registered).
REQ-016 nextPC  out  XLEN  combinational next-address candidate.
REQ-017 epc  out  XLEN  address of the last trapping instruction (registered).
REQ-018 halted, ras_empty, ras_full, fault  out  1 each  status outputs; fault is sticky.

Function
REQ-019 pc4 = curPC + 4, computed modulo 2^XLEN; all PC arithmetic wraps silently.
REQ-020 nextPC is selected by PCSrc:
  - SEQ: pc4.
  - BRANCH: pc4 + (Imm << 2) when BrTaken = 1, otherwise pc4.
  - JUMP: {pc4[XLEN-1:28], JTarget, 2'b00}.
  - REG: RegTarget.
  - RET: top of the RAS.
  - TRAP: TRAP_VEC.
REQ-021 The state machine has two states, RUN and HALT; halted = 1 exactly when the state is HALT.
REQ-022 An update occurs when, and only when, state = RUN, PCWre = 1 and Halt = 0; on an update, curPC takes nextPC at the next edge (1-cycle latency).
REQ-023 In RUN, Halt = 1 moves the state to HALT, holds curPC, and suppresses all RAS and epc writes; Halt takes priority over PCWre.
REQ-024 In HALT, Resume = 1 returns the state to RUN on the next edge with no PC update that cycle; Halt and PCWre are ignored while in HALT.
REQ-025 When PCWre = 0, curPC, epc and the RAS all hold.
REQ-026 On an update with PCSrc = TRAP, epc takes curPC.
REQ-027 On an update where nextPC[1:0] is not 00:
  - curPC takes TRAP_VEC;
  - epc takes curPC;
  - fault is set.
REQ-028 RET with an empty RAS:
  - curPC takes TRAP_VEC;
  - epc takes curPC;
  - fault is set;
  - the RAS pointer is unchanged.
REQ-029 On an update with Call = 1, pc4 is pushed onto the RAS. When the RAS is full, the push overwrites the oldest entry (circular), and the occupancy count saturates at RAS_DEPTH.
REQ-030 On an update with PCSrc = RET and a non-empty RAS, the top entry is popped and the count is decremented.
REQ-031 On an update with RET and Call = 1 together, the pop and the push occur in the same cycle: the top entry is replaced by pc4 and the count is unchanged.
REQ-032 Call has no effect on a cycle that produces a fault.
REQ-033 ras_empty = (count == 0) and ras_full = (count == RAS_DEPTH); both are registered-state derived and glitch-free.
REQ-034 fault clears only on reset.

Reset
REQ-035 Reset asserted low, asynchronously and at any point including mid-operation, sets:
  - curPC to RESET_VEC;
  - epc to 0;
  - the state to RUN;
  - the RAS count and pointer to 0;
  - fault to 0.
REQ-036 RAS entry contents need not be reset.
REQ-037 The first update after reset deasserts occurs at the first rising edge with PCWre = 1.

Structure
REQ-038 A shared package pc_pkg holds:
  - the PCSrc encoding constants;
  - the RUN/HALT state typedef;
  - the default RESET_VEC and TRAP_VEC.
REQ-039 The return-address stack is a sub-module pc_ras, parametrised by XLEN and RAS_DEPTH, with push, pop, top, empty and full.
REQ-040 Next-PC selection stays combinational inside pc_gen.

Verification
REQ-041 Reset, then 3 cycles of SEQ with PCWre = 1 -> curPC = 0, 4, 8, C.
REQ-042 At curPC = 0x10: BRANCH with BrTaken = 1, Imm = -2 -> curPC = 0x0C. Then JUMP with JTarget = 0x40 -> curPC = 0x100.
REQ-043 At curPC = 0x20: JUMP with Call = 1, then RET -> curPC = 0x24. Push 5 entries with RAS_DEPTH = 4, then 4 RETs -> returns in LIFO order with the oldest entry lost; ras_empty = 1 afterwards.
REQ-044 REG with RegTarget = 0x102, at curPC = 0x40 -> curPC = TRAP_VEC, epc = 0x40, fault = 1. A RET with an empty RAS gives the same response.
REQ-045 Halt for 3 cycles while PCWre = 1 -> curPC frozen and halted = 1. Then Resume -> halted = 0, and the next update resumes from the frozen PC.
REQ-046 Reset pulsed mid-cycle during an update -> curPC = RESET_VEC immediately (before the next edge), and fault and the RAS are cleared.
